// File: rtl/gb_if_pkg.sv
// Shared encodings for the GB interface responder: directions, data types,
// FSM states and header field placement.
package gb_if_pkg;

  localparam logic DIR_GB2HOST = 1'b0;
  localparam logic DIR_HOST2GB = 1'b1;

  typedef enum logic [2:0] {
    DTYPE_0, DTYPE_1, DTYPE_2, DTYPE_3,
    DTYPE_4, DTYPE_5, DTYPE_6, DTYPE_7
  } data_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  localparam int unsigned HDR_DIR_BIT    = 0;
  localparam int unsigned HDR_TYPE_LSB   = 1;
  localparam int unsigned HDR_TYPE_WIDTH = 3;
  localparam int unsigned HDR_LEN_LSB    = 4;

endpackage

// File: rtl/gb_if_pipe_reg.sv
// One-entry valid/ready register stage. Refills in the same cycle it drains,
// so it sustains one beat per cycle; en gates acceptance of new beats.
module gb_if_pipe_reg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_val,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_val,
  input  logic             dn_rdy,
  output logic [WIDTH-1:0] dn_data
);

  logic load;

  assign load   = !dn_val || dn_rdy;
  assign up_rdy = load && en;

  // Hold the entry while stalled; otherwise take the next beat or go empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dn_val  <= 1'b0;
      dn_data <= '0;
    end else if (load) begin
      dn_val <= up_val && en;
      if (up_val && en) dn_data <= up_data;
    end
  end

endmodule

// File: rtl/gb_if_responder.sv
// Off-chip responder for the GB configuration/data port: accepts one GB
// transfer request at a time, sends a header word to the host, then streams
// the burst host->GB (RD) or GB->host (WR) through a register stage.
module gb_if_responder
  import gb_if_pkg::*;
#(
  parameter int unsigned PORT_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  GBIF_cfg_val,
  output logic                  IFGB_cfg_rdy,
  input  logic [3:0]            GBIF_cfg_info,
  input  logic [LEN_WIDTH-1:0]  CFGIF_burst_len,
  input  logic                  GBIF_wr_val,
  output logic                  IFGB_wr_rdy,
  input  logic [PORT_WIDTH-1:0] GBIF_wr_data,
  output logic                  IFGB_rd_val,
  input  logic                  GBIF_rd_rdy,
  output logic [PORT_WIDTH-1:0] IFGB_rd_data,
  output logic                  IFHOST_val,
  input  logic                  HOSTIF_rdy,
  output logic [PORT_WIDTH-1:0] IFHOST_data,
  input  logic                  HOSTIF_val,
  output logic                  IFHOST_rdy,
  input  logic [PORT_WIDTH-1:0] HOSTIF_data,
  output logic                  IF_busy,
  output logic                  IF_done
);

  localparam logic [LEN_WIDTH:0] CNT_ONE = 1;

  state_t                  state;
  data_type_t              type_q;
  logic                    dir_q;
  logic [LEN_WIDTH:0]      len_q;
  logic [LEN_WIDTH:0]      in_cnt;
  logic [LEN_WIDTH:0]      out_cnt;
  logic                    hdr_val;
  logic [PORT_WIDTH-1:0]   hdr_word;

  logic                    rd_en, wr_en;
  logic                    rd_in_rdy, wr_in_rdy;
  logic                    wr_out_val;
  logic [PORT_WIDTH-1:0]   wr_out_data;
  logic                    in_hs, out_hs;

  assign IFGB_cfg_rdy = (state == ST_IDLE);
  assign IF_busy      = (state != ST_IDLE);
  assign IF_done      = (state == ST_DONE);

  assign rd_en = (state == ST_RD) && (in_cnt != '0);
  assign wr_en = (state == ST_WR) && (in_cnt != '0);

  assign IFHOST_rdy  = rd_in_rdy;
  assign IFGB_wr_rdy = wr_in_rdy;

  // The host output carries the header in HDR and WR beats afterwards; the
  // WR stage is always empty during HDR, so the valids can simply be ORed.
  assign IFHOST_val  = hdr_val || wr_out_val;
  assign IFHOST_data = (state == ST_HDR) ? hdr_word : wr_out_data;

  assign in_hs  = (HOSTIF_val && rd_in_rdy) || (GBIF_wr_val && wr_in_rdy);
  assign out_hs = (IFGB_rd_val && GBIF_rd_rdy) || (wr_out_val && HOSTIF_rdy);

  // Header word: direction in bit 0, type above it, stored length above that.
  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_DIR_BIT] = dir_q;
    hdr_word[HDR_TYPE_LSB +: HDR_TYPE_WIDTH] = type_q;
    hdr_word[HDR_LEN_LSB +: LEN_WIDTH+1] = len_q;
  end

  // Transfer sequencing, request latching, header valid and beat counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      type_q  <= DTYPE_0;
      dir_q   <= 1'b0;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      hdr_val <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (GBIF_cfg_val) begin
            type_q  <= data_type_t'(GBIF_cfg_info[3:1]);
            dir_q   <= GBIF_cfg_info[0];
            len_q   <= {CFGIF_burst_len == '0, CFGIF_burst_len};
            hdr_val <= 1'b1;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (hdr_val && HOSTIF_rdy) begin
            hdr_val <= 1'b0;
            in_cnt  <= len_q;
            out_cnt <= len_q;
            state   <= (dir_q == DIR_HOST2GB) ? ST_RD : ST_WR;
          end
        end
        ST_RD, ST_WR: begin
          if (in_hs) in_cnt <= in_cnt - CNT_ONE;
          if (out_hs) begin
            out_cnt <= out_cnt - CNT_ONE;
            if (out_cnt == CNT_ONE) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  gb_if_pipe_reg #(.WIDTH(PORT_WIDTH)) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (rd_en),
    .up_val  (HOSTIF_val),
    .up_rdy  (rd_in_rdy),
    .up_data (HOSTIF_data),
    .dn_val  (IFGB_rd_val),
    .dn_rdy  (GBIF_rd_rdy),
    .dn_data (IFGB_rd_data)
  );

  gb_if_pipe_reg #(.WIDTH(PORT_WIDTH)) u_wr_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wr_en),
    .up_val  (GBIF_wr_val),
    .up_rdy  (wr_in_rdy),
    .up_data (GBIF_wr_data),
    .dn_val  (wr_out_val),
    .dn_rdy  (HOSTIF_rdy),
    .dn_data (wr_out_data)
  );

endmodule

// File: tb/tb_gb_if_responder.sv
// Self-checking bench for gb_if_responder: scenario tasks drive bursts and
// compare observed headers/beats/timing against values derived from the
// burst parameters and the source beat queue.
module tb_gb_if_responder;

  localparam int unsigned PW = 128;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          GBIF_cfg_val;
  logic          IFGB_cfg_rdy;
  logic [3:0]    GBIF_cfg_info;
  logic [LW-1:0] CFGIF_burst_len;
  logic          GBIF_wr_val;
  logic          IFGB_wr_rdy;
  logic [PW-1:0] GBIF_wr_data;
  logic          IFGB_rd_val;
  logic          GBIF_rd_rdy;
  logic [PW-1:0] IFGB_rd_data;
  logic          IFHOST_val;
  logic          HOSTIF_rdy;
  logic [PW-1:0] IFHOST_data;
  logic          HOSTIF_val;
  logic          IFHOST_rdy;
  logic [PW-1:0] HOSTIF_data;
  logic          IF_busy;
  logic          IF_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gb_if_responder #(.PORT_WIDTH(PW), .LEN_WIDTH(LW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .GBIF_cfg_val    (GBIF_cfg_val),
    .IFGB_cfg_rdy    (IFGB_cfg_rdy),
    .GBIF_cfg_info   (GBIF_cfg_info),
    .CFGIF_burst_len (CFGIF_burst_len),
    .GBIF_wr_val     (GBIF_wr_val),
    .IFGB_wr_rdy     (IFGB_wr_rdy),
    .GBIF_wr_data    (GBIF_wr_data),
    .IFGB_rd_val     (IFGB_rd_val),
    .GBIF_rd_rdy     (GBIF_rd_rdy),
    .IFGB_rd_data    (IFGB_rd_data),
    .IFHOST_val      (IFHOST_val),
    .HOSTIF_rdy      (HOSTIF_rdy),
    .IFHOST_data     (IFHOST_data),
    .HOSTIF_val      (HOSTIF_val),
    .IFHOST_rdy      (IFHOST_rdy),
    .HOSTIF_data     (HOSTIF_data),
    .IF_busy         (IF_busy),
    .IF_done         (IF_done)
  );

  // Observations gathered by run_burst for the scenario tasks to judge.
  logic [PW-1:0] src_q[$];
  logic [PW-1:0] got_q[$];
  logic [PW-1:0] hdr_word;
  int  acc_cycle, hdr_val_cycle, hdr_cycle, first_in_cycle, first_out_val_cycle;
  int  out_first, out_last, in_count, done_cnt, done_cycle;
  int  stall_viol, stall_seen, stab_viol, busy_rdy_viol;
  bit  timed_out;

  function automatic logic [PW-1:0] rand_word();
    logic [PW-1:0] w;
    for (int i = 0; i < int'(PW / 32); i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // mode 0: always 1; mode 1: repeating 1,0,0,1; otherwise random.
  function automatic logic rdy_pat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4 == 1) || (cyc % 4 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [PW-1:0] exp_header(input logic [3:0] info, input logic [LW-1:0] len);
    int n;
    n = (len == 0) ? (1 << LW) : int'(len);
    return PW'(n * 16 + int'(info));
  endfunction

  // Drives one request and its burst; starts and ends at posedge+1.
  task automatic run_burst(input logic [3:0] info, input logic [LW-1:0] len,
                           input int out_mode, input int in_mode,
                           input bit hold_req, input int stop_after, input int budget);
    int n, cyc, src_idx;
    bit accepted, hdr_done, hdr_prev, fin, dir, in_hs, ov, ordy;
    bit prev_h_stall, prev_r_stall;
    logic [PW-1:0] prev_h_data, prev_r_data, od;
    n = (len == 0) ? (1 << LW) : int'(len);
    dir = info[0];
    src_q.delete();
    got_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(rand_word());
    hdr_word = '0;
    acc_cycle = -1; hdr_val_cycle = -1; hdr_cycle = -1;
    first_in_cycle = -1; first_out_val_cycle = -1; out_first = -1; out_last = -1;
    in_count = 0; done_cnt = 0; done_cycle = -1;
    stall_viol = 0; stall_seen = 0; stab_viol = 0; busy_rdy_viol = 0; timed_out = 0;
    cyc = 0; src_idx = 0; accepted = 0; hdr_done = 0; fin = 0;
    prev_h_stall = 0; prev_r_stall = 0; prev_h_data = '0; prev_r_data = '0;
    while (!fin) begin
      cyc++;
      if (cyc > budget) begin
        timed_out = 1;
        break;
      end
      GBIF_cfg_val    = hold_req || !accepted;
      GBIF_cfg_info   = info;
      CFGIF_burst_len = len;
      HOSTIF_rdy      = rdy_pat(out_mode, cyc);
      GBIF_rd_rdy     = rdy_pat(out_mode, cyc);
      if (dir) begin
        if (!HOSTIF_val) begin
          HOSTIF_val  = rdy_pat(in_mode, cyc);
          HOSTIF_data = (src_idx < n) ? src_q[src_idx] : rand_word();
        end
      end else begin
        if (!GBIF_wr_val) begin
          GBIF_wr_val  = rdy_pat(in_mode, cyc);
          GBIF_wr_data = (src_idx < n) ? src_q[src_idx] : rand_word();
        end
      end
      #1;
      if (IF_busy && IFGB_cfg_rdy) busy_rdy_viol++;
      if (!accepted && GBIF_cfg_val && IFGB_cfg_rdy) begin
        accepted = 1;
        acc_cycle = cyc;
      end
      if (prev_h_stall && (!IFHOST_val || IFHOST_data !== prev_h_data)) stab_viol++;
      if (prev_r_stall && (!IFGB_rd_val || IFGB_rd_data !== prev_r_data)) stab_viol++;
      prev_h_stall = IFHOST_val && !HOSTIF_rdy;
      prev_h_data  = IFHOST_data;
      prev_r_stall = IFGB_rd_val && !GBIF_rd_rdy;
      prev_r_data  = IFGB_rd_data;
      hdr_prev = hdr_done;
      if (accepted && !hdr_done && IFHOST_val) begin
        if (hdr_val_cycle < 0) hdr_val_cycle = cyc;
        if (HOSTIF_rdy) begin
          hdr_word = IFHOST_data;
          hdr_cycle = cyc;
          hdr_done = 1;
        end
      end
      in_hs = dir ? (HOSTIF_val && IFHOST_rdy) : (GBIF_wr_val && IFGB_wr_rdy);
      if (in_hs) begin
        if (first_in_cycle < 0) first_in_cycle = cyc;
        in_count++;
        src_idx++;
      end
      if (dir) begin
        ov = IFGB_rd_val; od = IFGB_rd_data; ordy = GBIF_rd_rdy;
      end else begin
        ov = hdr_prev && IFHOST_val; od = IFHOST_data; ordy = HOSTIF_rdy;
        if (ov && !ordy) stall_seen++;
        if (IFHOST_val && !HOSTIF_rdy && IFGB_wr_rdy) stall_viol++;
      end
      if (ov && first_out_val_cycle < 0) first_out_val_cycle = cyc;
      if (ov && ordy) begin
        got_q.push_back(od);
        if (out_first < 0) out_first = cyc;
        out_last = cyc;
      end
      if (IF_done) begin
        done_cnt++;
        done_cycle = cyc;
        fin = 1;
      end
      if (stop_after > 0 && got_q.size() >= stop_after) fin = 1;
      @(posedge clk);
      #1;
      if (in_hs) begin
        if (dir) HOSTIF_val = 1'b0;
        else GBIF_wr_val = 1'b0;
      end
    end
    HOSTIF_val  = 1'b0;
    GBIF_wr_val = 1'b0;
    HOSTIF_rdy  = 1'b0;
    GBIF_rd_rdy = 1'b0;
    if (!hold_req) GBIF_cfg_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    GBIF_cfg_val = 0; GBIF_cfg_info = '0; CFGIF_burst_len = '0;
    GBIF_wr_val = 0; GBIF_wr_data = '0; GBIF_rd_rdy = 0;
    HOSTIF_rdy = 0; HOSTIF_val = 0; HOSTIF_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({IFHOST_val, IFGB_rd_val, IFHOST_rdy, IFGB_wr_rdy, IF_busy, IF_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {IFHOST_val, IFGB_rd_val, IFHOST_rdy, IFGB_wr_rdy, IF_busy, IF_done});
    end
    checks++;
    if (IFHOST_data !== '0 || IFGB_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h/%0h expected 0/0", IFHOST_data, IFGB_rd_data);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (IFGB_cfg_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_cfg_rdy: got %b expected 1", IFGB_cfg_rdy);
    end
  endtask

  task automatic test_read_burst();
    run_burst(4'b0011, 8'd4, 0, 0, 0, 0, 100);
    checks++;
    if (timed_out) begin errors++; $display("FAIL rd_timeout: got timeout expected done"); end
    checks++;
    if (hdr_word !== PW'(128'h43)) begin
      errors++; $display("FAIL rd_header: got %0h expected 43", hdr_word);
    end
    checks++;
    if (hdr_val_cycle != acc_cycle + 1) begin
      errors++; $display("FAIL rd_header_latency: got %0d expected %0d", hdr_val_cycle, acc_cycle + 1);
    end
    checks++;
    if (first_out_val_cycle != first_in_cycle + 1) begin
      errors++; $display("FAIL rd_beat_latency: got %0d expected %0d", first_out_val_cycle, first_in_cycle + 1);
    end
    checks++;
    if (got_q.size() != 4 || got_q != src_q) begin
      errors++; $display("FAIL rd_data: got %0d beats expected 4 matching", got_q.size());
    end
    checks++;
    if (done_cnt != 1 || IF_done !== 1'b0 || IF_busy !== 1'b0) begin
      errors++; $display("FAIL rd_done_idle: got done=%0d IF_done=%b busy=%b expected 1/0/0", done_cnt, IF_done, IF_busy);
    end
  endtask

  task automatic test_write_backpressure();
    run_burst(4'b0100, 8'd3, 1, 0, 0, 0, 100);
    checks++;
    if (timed_out) begin errors++; $display("FAIL wr_timeout: got timeout expected done"); end
    checks++;
    if (hdr_word !== exp_header(4'b0100, 8'd3)) begin
      errors++; $display("FAIL wr_header: got %0h expected %0h", hdr_word, exp_header(4'b0100, 8'd3));
    end
    checks++;
    if (got_q.size() != 3 || got_q != src_q) begin
      errors++; $display("FAIL wr_data: got %0d beats expected 3 matching", got_q.size());
    end
    checks++;
    if (stall_viol != 0 || stall_seen == 0) begin
      errors++; $display("FAIL wr_stall_rdy: got viol=%0d stalls=%0d expected 0/>0", stall_viol, stall_seen);
    end
    checks++;
    if (stab_viol != 0) begin
      errors++; $display("FAIL wr_stable: got %0d expected 0", stab_viol);
    end
  endtask

  task automatic test_len_zero();
    run_burst(4'b1011, 8'd0, 0, 0, 0, 0, 1000);
    checks++;
    if (timed_out) begin errors++; $display("FAIL len0_timeout: got timeout expected done"); end
    checks++;
    if (hdr_word !== PW'(256 * 16 + 11)) begin
      errors++; $display("FAIL len0_header: got %0h expected %0h", hdr_word, PW'(256 * 16 + 11));
    end
    checks++;
    if (got_q.size() != 256 || got_q != src_q) begin
      errors++; $display("FAIL len0_data: got %0d beats expected 256 matching", got_q.size());
    end
    checks++;
    if (in_count != 256) begin
      errors++; $display("FAIL len0_no_overrun: got %0d accepted expected 256", in_count);
    end
  endtask

  task automatic test_busy_request();
    run_burst(4'b0011, 8'd6, 0, 0, 1, 0, 100);
    checks++;
    if (busy_rdy_viol != 0 || timed_out) begin
      errors++; $display("FAIL busy_cfg_rdy: got %0d ready-while-busy expected 0", busy_rdy_viol);
    end
    checks++;
    if (IFGB_cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL busy_idle_rdy: got %b expected 1", IFGB_cfg_rdy);
    end
    run_burst(4'b0011, 8'd6, 0, 0, 0, 0, 100);
    checks++;
    if (acc_cycle != 1) begin
      errors++; $display("FAIL busy_reaccept: got cycle %0d expected 1", acc_cycle);
    end
    checks++;
    if (hdr_word !== exp_header(4'b0011, 8'd6) || got_q != src_q) begin
      errors++; $display("FAIL busy_second_xfer: got hdr %0h expected %0h", hdr_word, exp_header(4'b0011, 8'd6));
    end
  endtask

  task automatic test_reset_mid();
    run_burst(4'b0001, 8'd8, 0, 0, 0, 2, 100);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({IFHOST_val, IFGB_rd_val, IFHOST_rdy, IFGB_wr_rdy, IF_busy, IF_done} !== 6'b0 ||
        IFHOST_data !== '0 || IFGB_rd_data !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got ctrl %b rd %0h expected 0", {IFHOST_val, IFGB_rd_val, IFHOST_rdy, IFGB_wr_rdy, IF_busy, IF_done}, IFGB_rd_data);
    end
    checks++;
    if (IFGB_cfg_rdy !== 1'b1) begin
      errors++; $display("FAIL midrst_idle: got cfg_rdy %b expected 1", IFGB_cfg_rdy);
    end
    rst_n = 1'b1;
    run_burst(4'b1101, 8'd5, 0, 0, 0, 0, 100);
    checks++;
    if (timed_out || hdr_word !== exp_header(4'b1101, 8'd5) || got_q != src_q || in_count != 5) begin
      errors++; $display("FAIL midrst_recover: got hdr %0h beats %0d expected %0h/5", hdr_word, got_q.size(), exp_header(4'b1101, 8'd5));
    end
  endtask

  task automatic test_throughput();
    run_burst(4'b0111, 8'd16, 0, 0, 0, 0, 100);
    checks++;
    if (got_q.size() != 16 || got_q != src_q || out_last - out_first != 15) begin
      errors++; $display("FAIL tput_consecutive: got span %0d beats %0d expected 15/16", out_last - out_first, got_q.size());
    end
    checks++;
    if (done_cycle < 0 || done_cycle - hdr_cycle > 18) begin
      errors++; $display("FAIL tput_done: got %0d cycles expected <= 18", done_cycle - hdr_cycle);
    end
  endtask

  task automatic test_random();
    logic [3:0] info;
    logic [LW-1:0] len;
    for (int it = 0; it < 8; it++) begin
      info = 4'($urandom_range(0, 15));
      len  = LW'($urandom_range(1, 24));
      run_burst(info, len, 2, 2, 0, 0, 2000);
      checks++;
      if (timed_out || hdr_word !== exp_header(info, len)) begin
        errors++; $display("FAIL rand_header[%0d]: got %0h expected %0h", it, hdr_word, exp_header(info, len));
      end
      checks++;
      if (got_q != src_q || in_count != int'(len)) begin
        errors++; $display("FAIL rand_data[%0d]: got %0d beats expected %0d matching", it, got_q.size(), len);
      end
      checks++;
      if (stab_viol != 0 || busy_rdy_viol != 0 || stall_viol != 0) begin
        errors++; $display("FAIL rand_protocol[%0d]: got stab=%0d busy=%0d stall=%0d expected 0", it, stab_viol, busy_rdy_viol, stall_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_backpressure();
    test_len_zero();
    test_busy_request();
    test_reset_mid();
    test_throughput();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
